// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer.
// Conditions the raw buttons and switches, runs the RUN/PAUSE/ADJ/CLR mode FSM,
// and produces the 1 Hz count tick, the 2 Hz adjust tick, the clear pulse and
// the display blink flag, all in the system clock domain.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | counting, prescaler advances, cnt_tick at 1 Hz
// PAUSE | counting frozen, prescaler and phase hold their value
// ADJ   | adjust mode, prescaler advances, adj_tick at 2 Hz, field blinks
// CLR   | one-cycle clear, prescaler and phase forced to 0
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic       sw_sel,
    input  logic       sw_adj,
    output logic       cnt_tick,
    output logic       adj_tick,
    output logic       adj_sel,
    output logic       clr,
    output logic       paused,
    output logic       blink,
    output logic [1:0] state
);

    localparam int HALF_DIV = CLK_HZ / 2;
    localparam int PW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int DW       = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(HALF_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_PAUSE = 2'b01,
        S_ADJ   = 2'b10,
        S_CLR   = 2'b11
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    // raw inputs packed as {sw_adj, sw_sel, btn_clear, btn_pause}
    logic [3:0] sync_a;
    logic [3:0] sync_b;

    logic [1:0]         db_lvl;
    logic [1:0]         db_lvl_q;
    logic [1:0][DW-1:0] db_cnt;
    logic [1:0]         press;
    logic               pause_ev;
    logic               clear_ev;
    logic               sw_adj_s;

    logic [PW-1:0] prescaler;
    logic          phase;
    logic          counting;
    logic          half_tick;

    logic cnt_tick_d;
    logic adj_tick_d;
    logic clr_d;

    // two-flop synchronizers for all four asynchronous board inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sw_adj, sw_sel, btn_clear, btn_pause};
            sync_b <= sync_a;
        end
    end

    assign sw_adj_s = sync_b[3];
    assign adj_sel  = sync_b[2];

    // debounce both buttons: a level change is accepted after DB_CYCLES stable cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_lvl   <= '0;
            db_lvl_q <= '0;
            db_cnt   <= '0;
        end else begin
            db_lvl_q <= db_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_lvl[i] <= ~db_lvl[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // only presses are events; releases are deliberately ignored
    assign press    = db_lvl & ~db_lvl_q;
    assign pause_ev = press[0];
    assign clear_ev = press[1];

    assign counting  = (cur_state == S_RUN) || (cur_state == S_ADJ);
    assign half_tick = counting && (prescaler == PRE_LAST);

    // half-second prescaler; phase selects which half of the second we are in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            phase     <= 1'b0;
        end else if (cur_state == S_CLR) begin
            prescaler <= '0;
            phase     <= 1'b0;
        end else if (counting) begin
            if (half_tick) begin
                prescaler <= '0;
                phase     <= ~phase;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_RUN;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // next-state logic; a clear press overrides everything, including a simultaneous pause
    always_comb begin
        nxt_state = cur_state;
        if (clear_ev) begin
            nxt_state = S_CLR;
        end else begin
            unique case (cur_state)
                S_RUN: begin
                    if (pause_ev)      nxt_state = S_PAUSE;
                    else if (sw_adj_s) nxt_state = S_ADJ;
                end
                S_PAUSE: begin
                    if (pause_ev) nxt_state = sw_adj_s ? S_ADJ : S_RUN;
                end
                S_ADJ: begin
                    if (pause_ev)       nxt_state = S_PAUSE;
                    else if (!sw_adj_s) nxt_state = S_RUN;
                end
                S_CLR: begin
                    nxt_state = sw_adj_s ? S_ADJ : S_RUN;
                end
                default: nxt_state = S_RUN;
            endcase
        end
    end

    // output decode; pulses are gated so none appears across a mode change that disallows it
    always_comb begin
        cnt_tick_d = half_tick && phase && (cur_state == S_RUN) && (nxt_state == S_RUN);
        adj_tick_d = half_tick && (cur_state == S_ADJ) && (nxt_state == S_ADJ);
        clr_d      = (nxt_state == S_CLR);
        paused     = (cur_state == S_PAUSE);
        blink      = (cur_state == S_ADJ) ? ~phase : 1'b1;
        state      = cur_state;
    end

    // registered one-cycle output pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_tick <= 1'b0;
            adj_tick <= 1'b0;
            clr      <= 1'b0;
        end else begin
            cnt_tick <= cnt_tick_d;
            adj_tick <= adj_tick_d;
            clr      <= clr_d;
        end
    end

endmodule
